// File: rtl/adder_pkg.sv
// Shared constants and golden arithmetic for the ripple-carry adder family.
// ref_add gives the full carry-inclusive result of a+b+cin at a chosen width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Operands are masked to 'width' bits; the result occupies bits [width:0].
  function automatic logic [64:0] ref_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic        cin,
                                          input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell; purely combinational link of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a single registered output stage,
// carry-out and two's-complement overflow flag.
module full_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   c_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             ovf_p0;

  logic [WIDTH-1:0] sum_p1;
  logic             carry_p1;
  logic             ovf_p1;
  logic             vld_p1;

  // Stage p0: combinational ripple chain
  assign c_p0[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c_p0[i]),
      .s    (sum_p0[i]),
      .cout (c_p0[i+1])
    );
  end

  assign ovf_p0 = c_p0[WIDTH] ^ c_p0[WIDTH-1];

  // Stage p1: output register; results only load when qualified, so
  // undriven operands during idle cycles never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1   <= '0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1   <= sum_p0;
        carry_p1 <= c_p0[WIDTH];
        ovf_p1   <= ovf_p0;
      end
    end
  end

  assign sum       = sum_p1;
  assign carry     = carry_p1;
  assign overflow  = ovf_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for the 4-bit full_adder: directed corner cases,
// hold/reset behaviour and randomized traffic against an arithmetic model.
module tb_full_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         out_valid;

  int total;
  int bad;

  full_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {out_valid, overflow, carry, sum}
  function automatic logic [W+2:0] observed();
    return {out_valid, overflow, carry, sum};
  endfunction

  // Expected {ovf, carry, sum} for a+b+cin using plain integer arithmetic;
  // overflow means the signed result lies outside [-2^(W-1), 2^(W-1)-1].
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic         ci);
    logic [64:0] r;
    int          sx, sy, ss;
    logic        ovf;
    r  = adder_pkg::ref_add(64'(x), 64'(y), ci, W);
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    ss = sx + sy + int'(ci);
    ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    return {ovf, r[W], r[W-1:0]};
  endfunction

  // Drive one cycle of inputs on the falling edge, then settle after the rising edge.
  task automatic apply(input logic r, input logic v, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    rst = r; in_valid = v; a = x; b = y; cin = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 4'd5, 4'd9, 1'b1);
    total++;
    if (sum !== 4'd0) begin bad++; $display("FAIL reset_sum got=%b want=0000", sum); end
    total++;
    if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", carry); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_zero();
    apply(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    total++;
    if (observed() !== 7'b1_0_0_0000) begin
      bad++; $display("FAIL zero got=%b want=%b", observed(), 7'b1_0_0_0000);
    end
  endtask

  task automatic test_carry_ripple();
    apply(1'b0, 1'b1, 4'd15, 4'd1, 1'b0);
    total++;
    if (observed() !== 7'b1_0_1_0000) begin
      bad++; $display("FAIL carry_ripple got=%b want=%b", observed(), 7'b1_0_1_0000);
    end
  endtask

  task automatic test_max();
    apply(1'b0, 1'b1, 4'd15, 4'd15, 1'b1);
    total++;
    if ({out_valid, carry, sum} !== 6'b1_1_1111) begin
      bad++; $display("FAIL max_all_ones got=%b want=%b", {out_valid, carry, sum}, 6'b1_1_1111);
    end
    apply(1'b0, 1'b1, 4'd9, 4'd6, 1'b0);
    total++;
    if ({out_valid, carry, sum} !== 6'b1_0_1111) begin
      bad++; $display("FAIL max_no_carry got=%b want=%b", {out_valid, carry, sum}, 6'b1_0_1111);
    end
  endtask

  task automatic test_signed_overflow();
    apply(1'b0, 1'b1, 4'd7, 4'd1, 1'b0);
    total++;
    if (observed() !== 7'b1_1_0_1000) begin
      bad++; $display("FAIL ovf_positive got=%b want=%b", observed(), 7'b1_1_0_1000);
    end
    apply(1'b0, 1'b1, 4'd8, 4'd8, 1'b0);
    total++;
    if (observed() !== 7'b1_1_1_0000) begin
      bad++; $display("FAIL ovf_negative got=%b want=%b", observed(), 7'b1_1_1_0000);
    end
  endtask

  task automatic test_hold_and_reset_priority();
    apply(1'b0, 1'b1, 4'd3, 4'd4, 1'b0);
    total++;
    if (observed() !== 7'b1_0_0_0111) begin
      bad++; $display("FAIL hold_load got=%b want=%b", observed(), 7'b1_0_0_0111);
    end
    apply(1'b0, 1'b0, 4'd15, 4'bxxxx, 1'bx);
    total++;
    if (observed() !== 7'b0_0_0_0111) begin
      bad++; $display("FAIL hold_idle got=%b want=%b", observed(), 7'b0_0_0_0111);
    end
    apply(1'b1, 1'b1, 4'd15, 4'd15, 1'b1);
    total++;
    if (observed() !== 7'b0_0_0_0000) begin
      bad++; $display("FAIL reset_priority got=%b want=%b", observed(), 7'b0_0_0_0000);
    end
  endtask

  // Back-to-back random traffic with occasional resets and idle cycles.
  task automatic test_random();
    logic [W+1:0] held;
    logic         exp_vld;
    logic         r, v, ci;
    logic [W-1:0] x, y;
    apply(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    held = '0;
    for (int n = 0; n < 1000; n++) begin
      r  = ($urandom_range(0, 31) == 0);
      v  = 1'($urandom_range(0, 3) != 0);
      x  = W'($urandom);
      y  = W'($urandom);
      ci = 1'($urandom);
      if (r) begin
        held = '0; exp_vld = 1'b0;
      end else begin
        exp_vld = v;
        if (v) held = model(x, y, ci);
      end
      apply(r, v, x, y, ci);
      total++;
      if (observed() !== {exp_vld, held}) begin
        bad++;
        $display("FAIL random[%0d] a=%0d b=%0d cin=%0d v=%0d rst=%0d got=%b want=%b",
                 n, x, y, ci, v, r, observed(), {exp_vld, held});
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_zero();
    test_carry_ripple();
    test_max();
    test_signed_overflow();
    test_hold_and_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
